// File: rtl/result_bcd_pkg.sv
// rtl/result_bcd_pkg.sv - shared types and constants for the result-to-BCD converter
package result_bcd_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;

    localparam logic [3:0] BCD_ADJ    = 4'd3;
    localparam logic [3:0] BCD_THRESH = 4'd5;

    // Active-low segment patterns, bit order gfedcba
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/result_bcd_conv_bcd_to_7seg.sv
// rtl/result_bcd_conv_bcd_to_7seg.sv - one BCD digit to active-low gfedcba segments
module bcd_to_7seg
    import result_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (digit_i)
            4'd0: seg_o = SEG_0;
            4'd1: seg_o = SEG_1;
            4'd2: seg_o = SEG_2;
            4'd3: seg_o = SEG_3;
            4'd4: seg_o = SEG_4;
            4'd5: seg_o = SEG_5;
            4'd6: seg_o = SEG_6;
            4'd7: seg_o = SEG_7;
            4'd8: seg_o = SEG_8;
            4'd9: seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/result_bcd_conv.sv
// rtl/result_bcd_conv.sv - sequential double-dabble sign-magnitude BCD converter (option RESULT_BCD_SEVSEG_EN)
module result_bcd_conv
    import result_bcd_pkg::*;
#(
    parameter int IN_W   = 5,
    parameter int DIGITS = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       value,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  busy
`ifdef RESULT_BCD_SEVSEG_EN
    ,
    output logic [7*DIGITS-1:0]   seg,
    output logic                  seg_minus
`endif
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(IN_W + 1);

    if (10**DIGITS <= 2**IN_W - 1) begin : g_bad_digits
        $error("result_bcd_conv: DIGITS too small to hold 2**IN_W-1");
    end

    conv_state_t       state_q, state_d;
    logic [IN_W-1:0]   mag_q, mag_d;
    logic [BW-1:0]     scratch_q, scratch_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_cap_q, neg_cap_d;
    logic [BW-1:0]     bcd_q, bcd_d;
    logic              neg_q, neg_d;

    logic [IN_W-2:0]   value_lo, value_lo_neg;
    logic [IN_W-1:0]   mag_in;
    logic              neg_in;
    logic [BW-1:0]     scratch_adj, scratch_sh;
    logic [IN_W-1:0]   mag_sh;
    logic              load_out;

    // A set MSB on a subtraction is a borrow: the low bits are a negative two's-complement sum
    assign value_lo     = value[IN_W-2:0];
    assign value_lo_neg = ~value_lo + {{(IN_W-2){1'b0}}, 1'b1};

    always_comb begin
        neg_in = 1'b0;
        mag_in = value;
        if (sub) begin
            neg_in = value[IN_W-1];
            mag_in = {1'b0, value[IN_W-1] ? value_lo_neg : value_lo};
        end
    end

    always_comb begin
        scratch_adj = scratch_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (scratch_q[4*k +: 4] >= BCD_THRESH)
                scratch_adj[4*k +: 4] = scratch_q[4*k +: 4] + BCD_ADJ;
        end
    end

    assign scratch_sh = {scratch_adj[BW-2:0], mag_q[IN_W-1]};
    assign mag_sh     = {mag_q[IN_W-2:0], 1'b0};
    assign load_out   = (state_q == SHIFT) && (cnt_q == CW'(1));

    always_comb begin
        state_d   = state_q;
        mag_d     = mag_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        neg_cap_d = neg_cap_q;
        bcd_d     = bcd_q;
        neg_d     = neg_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mag_d     = mag_in;
                    neg_cap_d = neg_in;
                    scratch_d = '0;
                    cnt_d     = CW'(IN_W);
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                busy      = 1'b1;
                scratch_d = scratch_sh;
                mag_d     = mag_sh;
                cnt_d     = cnt_q - CW'(1);
                if (load_out) begin
                    bcd_d   = scratch_sh;
                    neg_d   = neg_cap_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            mag_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            neg_cap_q <= 1'b0;
            bcd_q     <= '0;
            neg_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mag_q     <= mag_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            neg_cap_q <= neg_cap_d;
            bcd_q     <= bcd_d;
            neg_q     <= neg_d;
        end
    end

    assign bcd = bcd_q;
    assign neg = neg_q;

`ifdef RESULT_BCD_SEVSEG_EN
    logic [7*DIGITS-1:0] seg_d, seg_q;
    logic                seg_minus_q;

    // Decode the final shifted value so segments load on the same edge as bcd
    for (genvar g = 0; g < DIGITS; g++) begin : g_dec
        bcd_to_7seg u_dec (
            .digit_i (scratch_sh[4*g +: 4]),
            .seg_o   (seg_d[7*g +: 7])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q       <= '1;
            seg_minus_q <= 1'b1;
        end else if (load_out) begin
            seg_q       <= seg_d;
            seg_minus_q <= ~neg_cap_q;
        end
    end

    assign seg       = seg_q;
    assign seg_minus = seg_minus_q;
`endif

endmodule

// File: tb/tb_result_bcd_conv.sv
// tb/tb_result_bcd_conv.sv - directed self-checking bench for result_bcd_conv
module tb_result_bcd_conv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  value = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  bcd;
    logic        neg;
    logic        busy;
`ifdef RESULT_BCD_SEVSEG_EN
    logic [13:0] seg;
    logic        seg_minus;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    result_bcd_conv #(.IN_W(5), .DIGITS(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .value     (value),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd       (bcd),
        .neg       (neg),
        .busy      (busy)
`ifdef RESULT_BCD_SEVSEG_EN
        ,
        .seg       (seg),
        .seg_minus (seg_minus)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake at a negedge, then count edges until out_valid (expected IN_W = 5)
    task automatic convert(input string tag, input logic [4:0] v, input logic s,
                           input logic [7:0] exp_bcd, input logic exp_neg, input bit consume);
        int n;
        @(negedge clk);
        value    = v;
        sub      = s;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_busy"}, busy, 1);
        check({tag, "_in_ready_shift"}, in_ready, 0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check({tag, "_latency"}, n, 5);
        check({tag, "_bcd"}, bcd, exp_bcd);
        check({tag, "_neg"}, neg, exp_neg);
        if (consume) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            check({tag, "_idle_ready"}, in_ready, 1);
            check({tag, "_idle_valid"}, out_valid, 0);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_bcd", bcd, 8'h00);
        check("rst_neg", neg, 0);
`ifdef RESULT_BCD_SEVSEG_EN
        check("rst_seg", seg, 14'h3FFF);
        check("rst_seg_minus", seg_minus, 1);
`endif
        rst = 1'b0;

        convert("add_9p8",   5'b10001, 1'b0, 8'h17, 1'b0, 1'b1);
        convert("sub_3m5",   5'b11110, 1'b1, 8'h02, 1'b1, 1'b1);
        convert("sub_0m15",  5'b10001, 1'b1, 8'h15, 1'b1, 1'b1);
        convert("sub_eq",    5'b00000, 1'b1, 8'h00, 1'b0, 1'b1);
        convert("add_zero",  5'b00000, 1'b0, 8'h00, 1'b0, 1'b1);
        convert("add_max",   5'b11111, 1'b0, 8'h31, 1'b0, 1'b1);
        convert("sub_pos",   5'b01001, 1'b1, 8'h09, 1'b0, 1'b1);

        // Stall with out_ready low; a second word offered mid-stall must be dropped
        convert("add_15p15", 5'b11110, 1'b0, 8'h30, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                value    = 5'b00001;
                sub      = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_bcd", bcd, 8'h30);
            check("stall_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("no_queue_valid", out_valid, 0);
        check("no_queue_busy", busy, 0);
        check("hold_bcd_idle", bcd, 8'h30);

        // Asynchronous reset in the 3rd SHIFT cycle
        value    = 5'b10101;
        sub      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_in_ready", in_ready, 1);
        check("arst_busy", busy, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_bcd", bcd, 8'h00);
        check("arst_neg", neg, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("arst_no_partial", out_valid, 0);
        convert("post_rst",  5'b00111, 1'b0, 8'h07, 1'b0, 1'b1);

        // Reset while a result is waiting in DONE
        convert("done_rst",  5'b10001, 1'b1, 8'h15, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("drst_out_valid", out_valid, 0);
        check("drst_bcd", bcd, 8'h00);
        check("drst_neg", neg, 0);
        @(negedge clk);
        rst = 1'b0;

`ifdef RESULT_BCD_SEVSEG_EN
        convert("seg_8",     5'b01000, 1'b0, 8'h08, 1'b0, 1'b1);
        check("seg_digits", seg, {7'b1000000, 7'b0000000});
        check("seg_minus_pos", seg_minus, 1);
        convert("seg_neg",   5'b11110, 1'b1, 8'h02, 1'b1, 1'b1);
        check("seg_digits_neg", seg, {7'b1000000, 7'b0100100});
        check("seg_minus_neg", seg_minus, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
